// File: rtl/time_set_ctrl.sv
// Front-panel set sequencer: RUN -> EDIT_H -> EDIT_M -> COMMIT, with inactivity
// timeout, field blink and a one-cycle load strobe for the hour/minute counters.
module time_set_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned BLINK_HALF     = 250,
   parameter int unsigned HOUR_MAX       = 23,
   parameter int unsigned MINUTE_MAX     = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_pulse,
   input  logic       inc_pulse,
   input  logic       dec_pulse,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_minute,
   output logic [4:0] set_hour,
   output logic [5:0] set_minute,
   output logic       set,
   output logic       editing,
   output logic [1:0] edit_field,
   output logic       blink
);

   localparam int unsigned HW   = 5;
   localparam int unsigned MW   = 6;
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      EDIT_H = 2'd1,
      EDIT_M = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t          state;
   logic [HW-1:0]   edit_h;
   logic [MW-1:0]   edit_m;
   logic [TO_W-1:0] to_cnt;
   logic [BL_W-1:0] bl_cnt;

   logic [HW-1:0]   hour_cap, hour_up, hour_dn;
   logic [MW-1:0]   minute_cap, minute_up, minute_dn;
   logic            to_expired, bl_wrap;

   // Captured live values are clamped to zero when out of range; edits wrap at the limits.
   assign hour_cap   = (cur_hour > HW'(HOUR_MAX)) ? '0 : cur_hour;
   assign minute_cap = (cur_minute > MW'(MINUTE_MAX)) ? '0 : cur_minute;
   assign hour_up    = (edit_h == HW'(HOUR_MAX)) ? '0 : edit_h + HW'(1);
   assign hour_dn    = (edit_h == '0) ? HW'(HOUR_MAX) : edit_h - HW'(1);
   assign minute_up  = (edit_m == MW'(MINUTE_MAX)) ? '0 : edit_m + MW'(1);
   assign minute_dn  = (edit_m == '0) ? MW'(MINUTE_MAX) : edit_m - MW'(1);

   assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign bl_wrap    = (bl_cnt == BL_W'(BLINK_HALF - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         edit_h     <= '0;
         edit_m     <= '0;
         to_cnt     <= '0;
         bl_cnt     <= '0;
         set_hour   <= '0;
         set_minute <= '0;
         set        <= 1'b0;
         editing    <= 1'b0;
         edit_field <= 2'd0;
         blink      <= 1'b0;
      end else begin
         set        <= 1'b0;
         set_hour   <= edit_h;
         set_minute <= edit_m;
         case (state)
            RUN: begin
               if (mode_pulse) begin
                  state      <= EDIT_H;
                  edit_h     <= hour_cap;
                  edit_m     <= minute_cap;
                  to_cnt     <= '0;
                  bl_cnt     <= '0;
                  blink      <= 1'b1;
                  editing    <= 1'b1;
                  edit_field <= 2'd1;
               end
            end
            EDIT_H, EDIT_M: begin
               // Free-running blink; later branches override it on field change or exit.
               bl_cnt <= bl_wrap ? '0 : bl_cnt + BL_W'(1);
               if (bl_wrap) blink <= ~blink;
               if (mode_pulse) begin
                  to_cnt <= '0;
                  bl_cnt <= '0;
                  if (state == EDIT_H) begin
                     state      <= EDIT_M;
                     blink      <= 1'b1;
                     edit_field <= 2'd2;
                  end else begin
                     state      <= COMMIT;
                     set        <= 1'b1;
                     blink      <= 1'b0;
                     editing    <= 1'b0;
                     edit_field <= 2'd0;
                  end
               end else if (inc_pulse || dec_pulse) begin
                  // inc+dec together is activity but leaves the field alone.
                  to_cnt <= '0;
                  if (inc_pulse && !dec_pulse) begin
                     if (state == EDIT_H) edit_h <= hour_up;
                     else                 edit_m <= minute_up;
                  end else if (dec_pulse && !inc_pulse) begin
                     if (state == EDIT_H) edit_h <= hour_dn;
                     else                 edit_m <= minute_dn;
                  end
               end else if (to_expired) begin
                  state      <= RUN;
                  to_cnt     <= '0;
                  bl_cnt     <= '0;
                  blink      <= 1'b0;
                  editing    <= 1'b0;
                  edit_field <= 2'd0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            COMMIT: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule
